// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback arbiter slice.
// Optional lookup feature is enabled with WB_PENDING_EN.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 4;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // A dead entry never matches, so killed loads drop out of lookups and kills alike.
  function automatic logic addr_hit(input logic live, input logic [WB_ADDR_W-1:0] a,
                                    input logic [WB_ADDR_W-1:0] b);
    return live && (a == b);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus between the ALU/load producers and the writeback arbiter.
// WB_PENDING_EN adds the lk_a/lk_pending register-busy lookup.
interface wb_arbiter_if #(
  parameter int DATA_W = wb_pkg::WB_DATA_W,
  parameter int ADDR_W = wb_pkg::WB_ADDR_W,
  parameter int DEPTH  = wb_pkg::WB_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_wa;
  logic [DATA_W-1:0] alu_wd;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              rw;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [CNT_W-1:0]  fifo_count;
`ifdef WB_PENDING_EN
  logic [ADDR_W-1:0] lk_a;
  logic              lk_pending;

  modport master (
    output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd, lk_a,
    input  mem_ready, rw, wa, wd, fifo_count, lk_pending
  );
  modport slave (
    input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd, lk_a,
    output mem_ready, rw, wa, wd, fifo_count, lk_pending
  );
`else
  modport master (
    output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
    input  mem_ready, rw, wa, wd, fifo_count
  );
  modport slave (
    input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
    output mem_ready, rw, wa, wd, fifo_count
  );
`endif

endinterface

// File: rtl/wb_fifo.sv
// Circular load buffer with per-entry kill-by-address.
// WB_PENDING_EN exposes a per-slot live address match vector.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  input  logic                       kill_valid,
  input  logic [WB_ADDR_W-1:0]       kill_addr,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
`ifdef WB_PENDING_EN
  ,
  input  logic [WB_ADDR_W-1:0]       lk_a,
  output logic [DEPTH-1:0]           match_vec
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        slots_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Slot storage, pointers and occupancy. Popped slots are cleared to dead so
  // unoccupied slots can never match a kill or a lookup.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        slots_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_valid && (slots_r[i].addr == kill_addr)) begin
          slots_r[i].live <= 1'b0;
        end
      end
      if (pop) begin
        slots_r[rd_ptr_r].live <= 1'b0;
        rd_ptr_r               <= rd_ptr_r + 1'b1;
      end
      if (push) begin
        slots_r[wr_ptr_r] <= push_entry;
        wr_ptr_r          <= wr_ptr_r + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = slots_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {CNT_W{1'b0}});
  assign full  = (count_r == CNT_W'(DEPTH));

`ifdef WB_PENDING_EN
  // Live-entry address match for the decode-stage lookup.
  always_comb begin
    match_vec = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = addr_hit(slots_r[i].live, slots_r[i].addr, lk_a);
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take the regfile port, queued loads fill idle cycles.
// Define WB_PENDING_EN to add the lk_a/lk_pending busy-register lookup.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input logic          clk,
  input logic          reset,
  wb_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push_s;
  logic              pop_s;
  wb_entry_t         push_entry_s;
  wb_entry_t         head_s;
  logic [CNT_W-1:0]  count_s;
  logic              empty_s;
  logic              full_s;
  logic              rw_r;
  logic [ADDR_W-1:0] wa_r;
  logic [DATA_W-1:0] wd_r;
`ifdef WB_PENDING_EN
  logic [DEPTH-1:0]  match_vec_s;
`endif

  assign bus.mem_ready = !reset && !full_s;
  assign push_s        = bus.mem_valid && bus.mem_ready;
  assign pop_s         = !bus.alu_valid && !empty_s;

  // A load arriving alongside an ALU write to the same register is older, so it enters dead.
  always_comb begin
    push_entry_s      = '0;
    push_entry_s.live = !(bus.alu_valid && (bus.alu_wa == bus.mem_wa));
    push_entry_s.addr = bus.mem_wa;
    push_entry_s.data = bus.mem_wd;
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .kill_valid (bus.alu_valid),
    .kill_addr  (bus.alu_wa),
    .head       (head_s),
    .count      (count_s),
    .empty      (empty_s),
    .full       (full_s)
`ifdef WB_PENDING_EN
    ,
    .lk_a       (bus.lk_a),
    .match_vec  (match_vec_s)
`endif
  );

  // Output register: ALU first, then FIFO head; a dead head burns the cycle with rw=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_r <= 1'b0;
      wa_r <= {ADDR_W{1'b0}};
      wd_r <= {DATA_W{1'b0}};
    end else if (bus.alu_valid) begin
      rw_r <= 1'b1;
      wa_r <= bus.alu_wa;
      wd_r <= bus.alu_wd;
    end else if (pop_s && head_s.live) begin
      rw_r <= 1'b1;
      wa_r <= head_s.addr;
      wd_r <= head_s.data;
    end else begin
      rw_r <= 1'b0;
      wa_r <= wa_r;
      wd_r <= wd_r;
    end
  end

  assign bus.rw         = rw_r;
  assign bus.wa         = wa_r;
  assign bus.wd         = wd_r;
  assign bus.fifo_count = count_s;

`ifdef WB_PENDING_EN
  assign bus.lk_pending = (|match_vec_s) || (rw_r && (wa_r == bus.lk_a));
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; the lookup scenario runs only when WB_PENDING_EN is defined.
module tb_wb_arbiter;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  wb_arbiter_if #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) bus ();

  wb_arbiter #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_wa    = 4'd0;
    bus.alu_wd    = 16'h0000;
    bus.mem_valid = 1'b0;
    bus.mem_wa    = 4'd0;
    bus.mem_wd    = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    tests_run++;
    if (bus.mem_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_c1: got %0b want 0", bus.mem_ready); end
    step();
    tests_run++;
    if (bus.rw !== 1'b0) begin tests_failed++; $display("FAIL reset_rw: got %0b want 0", bus.rw); end
    tests_run++;
    if (bus.wa !== 4'd0 || bus.wd !== 16'h0000) begin tests_failed++; $display("FAIL reset_wa_wd: got %0h/%0h want 0/0", bus.wa, bus.wd); end
    tests_run++;
    if (bus.mem_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_c2: got %0b want 0", bus.mem_ready); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.mem_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after: got %0b want 1", bus.mem_ready); end
    tests_run++;
    if (bus.fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_alu_single();
    bus.alu_valid = 1'b1; bus.alu_wa = 4'd3; bus.alu_wd = 16'hBEEF;
    step();
    bus.alu_valid = 1'b0;
    tests_run++;
    if (bus.rw !== 1'b1 || bus.wa !== 4'd3 || bus.wd !== 16'hBEEF) begin
      tests_failed++; $display("FAIL alu_write: got rw=%0b wa=%0h wd=%0h want 1/3/beef", bus.rw, bus.wa, bus.wd);
    end
    step();
    tests_run++;
    if (bus.rw !== 1'b0 || bus.wa !== 4'd3) begin
      tests_failed++; $display("FAIL alu_idle_after: got rw=%0b wa=%0h want 0/3", bus.rw, bus.wa);
    end
  endtask

  task automatic test_alu_priority();
    logic [3:0] alu_seq [3];
    alu_seq[0] = 4'd1; alu_seq[1] = 4'd2; alu_seq[2] = 4'd4;
    bus.alu_valid = 1'b1; bus.alu_wa = alu_seq[0]; bus.alu_wd = 16'h0101;
    bus.mem_valid = 1'b1; bus.mem_wa = 4'd5; bus.mem_wd = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.mem_valid = 1'b0;
      if (i < 2) begin
        bus.alu_wa = alu_seq[i+1]; bus.alu_wd = 16'h0101 * (i + 2);
      end else begin
        bus.alu_valid = 1'b0;
      end
      tests_run++;
      if (bus.rw !== 1'b1 || bus.wa !== alu_seq[i] || bus.fifo_count !== 3'd1) begin
        tests_failed++; $display("FAIL prio_alu%0d: got rw=%0b wa=%0h cnt=%0d want 1/%0h/1", i, bus.rw, bus.wa, bus.fifo_count, alu_seq[i]);
      end
    end
    step();
    tests_run++;
    if (bus.rw !== 1'b1 || bus.wa !== 4'd5 || bus.wd !== 16'h1234 || bus.fifo_count !== 3'd0) begin
      tests_failed++; $display("FAIL prio_load: got rw=%0b wa=%0h wd=%0h cnt=%0d want 1/5/1234/0", bus.rw, bus.wa, bus.wd, bus.fifo_count);
    end
    step();
    tests_run++;
    if (bus.rw !== 1'b0) begin tests_failed++; $display("FAIL prio_idle: got %0b want 0", bus.rw); end
  endtask

  task automatic test_fifo_full();
    logic [3:0] exp_wa;
    bus.alu_valid = 1'b1; bus.alu_wa = 4'd14; bus.alu_wd = 16'h00EE;
    for (int i = 0; i < 5; i++) begin
      bus.mem_valid = 1'b1; bus.mem_wa = 4'(8 + i); bus.mem_wd = 16'(16'hA000 + i);
      #1;
      tests_run++;
      if (bus.mem_ready !== (i < 4 ? 1'b1 : 1'b0)) begin
        tests_failed++; $display("FAIL full_ready%0d: got %0b want %0b", i, bus.mem_ready, (i < 4 ? 1'b1 : 1'b0));
      end
      step();
    end
    bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
    tests_run++;
    if (bus.fifo_count !== 3'd4) begin tests_failed++; $display("FAIL full_count: got %0d want 4", bus.fifo_count); end
    for (int j = 0; j < 4; j++) begin
      step();
      exp_wa = 4'(8 + j);
      tests_run++;
      if (bus.rw !== 1'b1 || bus.wa !== exp_wa || bus.wd !== 16'(16'hA000 + j) || bus.fifo_count !== 3'(3 - j)) begin
        tests_failed++; $display("FAIL drain%0d: got rw=%0b wa=%0h wd=%0h cnt=%0d want 1/%0h/%0h/%0d",
                                 j, bus.rw, bus.wa, bus.wd, bus.fifo_count, exp_wa, 16'(16'hA000 + j), 3 - j);
      end
    end
    step();
    tests_run++;
    if (bus.rw !== 1'b0) begin tests_failed++; $display("FAIL drain_idle: got %0b want 0", bus.rw); end
  endtask

  task automatic test_kill();
    bus.mem_valid = 1'b1; bus.mem_wa = 4'd7; bus.mem_wd = 16'h1111;
    step();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_wa = 4'd7; bus.alu_wd = 16'h2222;
    tests_run++;
    if (bus.fifo_count !== 3'd1 || bus.rw !== 1'b0) begin
      tests_failed++; $display("FAIL kill_queued: got cnt=%0d rw=%0b want 1/0", bus.fifo_count, bus.rw);
    end
    step();
    bus.alu_valid = 1'b0;
    tests_run++;
    if (bus.rw !== 1'b1 || bus.wa !== 4'd7 || bus.wd !== 16'h2222) begin
      tests_failed++; $display("FAIL kill_alu: got rw=%0b wa=%0h wd=%0h want 1/7/2222", bus.rw, bus.wa, bus.wd);
    end
    step();
    tests_run++;
    if (bus.rw !== 1'b0 || bus.wd !== 16'h2222 || bus.fifo_count !== 3'd0) begin
      tests_failed++; $display("FAIL kill_drain: got rw=%0b wd=%0h cnt=%0d want 0/2222/0", bus.rw, bus.wd, bus.fifo_count);
    end
    step();
    tests_run++;
    if (bus.rw !== 1'b0 || bus.fifo_count !== 3'd0) begin
      tests_failed++; $display("FAIL kill_final: got rw=%0b cnt=%0d want 0/0", bus.rw, bus.fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.alu_valid = 1'b1; bus.alu_wa = 4'd15; bus.alu_wd = 16'h0F0F;
    for (int i = 0; i < 3; i++) begin
      bus.mem_valid = 1'b1; bus.mem_wa = 4'(1 + i); bus.mem_wd = 16'(16'hC000 + i);
      step();
    end
    bus.mem_valid = 1'b0;
    tests_run++;
    if (bus.fifo_count !== 3'd3) begin tests_failed++; $display("FAIL mid_count: got %0d want 3", bus.fifo_count); end
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.mem_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_ready: got %0b want 0", bus.mem_ready); end
    step();
    reset = 1'b0; bus.alu_valid = 1'b0;
    tests_run++;
    if (bus.rw !== 1'b0 || bus.wa !== 4'd0 || bus.fifo_count !== 3'd0) begin
      tests_failed++; $display("FAIL mid_reset: got rw=%0b wa=%0h cnt=%0d want 0/0/0", bus.rw, bus.wa, bus.fifo_count);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (bus.rw !== 1'b0 || bus.fifo_count !== 3'd0) begin
        tests_failed++; $display("FAIL mid_after%0d: got rw=%0b cnt=%0d want 0/0", k, bus.rw, bus.fifo_count);
      end
    end
  endtask

`ifdef WB_PENDING_EN
  task automatic test_pending();
    bus.alu_valid = 1'b1; bus.alu_wa = 4'd10; bus.alu_wd = 16'h00AA;
    bus.mem_valid = 1'b1; bus.mem_wa = 4'd6; bus.mem_wd = 16'h6666;
    step();
    bus.mem_valid = 1'b0;
    bus.lk_a = 4'd6; #1;
    tests_run++;
    if (bus.lk_pending !== 1'b1) begin tests_failed++; $display("FAIL pend_queued: got %0b want 1", bus.lk_pending); end
    bus.lk_a = 4'd9; #1;
    tests_run++;
    if (bus.lk_pending !== 1'b0) begin tests_failed++; $display("FAIL pend_other: got %0b want 0", bus.lk_pending); end
    bus.lk_a = 4'd10; #1;
    tests_run++;
    if (bus.lk_pending !== 1'b1) begin tests_failed++; $display("FAIL pend_outreg: got %0b want 1", bus.lk_pending); end
    bus.alu_wa = 4'd6; bus.alu_wd = 16'h0606; bus.lk_a = 4'd6;
    step();
    bus.alu_valid = 1'b0;
    tests_run++;
    if (bus.lk_pending !== 1'b1 || bus.rw !== 1'b1 || bus.wa !== 4'd6) begin
      tests_failed++; $display("FAIL pend_killed_rw: got pend=%0b rw=%0b wa=%0h want 1/1/6", bus.lk_pending, bus.rw, bus.wa);
    end
    step();
    tests_run++;
    if (bus.lk_pending !== 1'b0 || bus.rw !== 1'b0) begin
      tests_failed++; $display("FAIL pend_cleared: got pend=%0b rw=%0b want 0/0", bus.lk_pending, bus.rw);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    idle_inputs();
`ifdef WB_PENDING_EN
    bus.lk_a = 4'd0;
`endif
    test_reset();
    test_alu_single();
    test_alu_priority();
    test_fifo_full();
    test_kill();
    test_reset_mid();
`ifdef WB_PENDING_EN
    test_pending();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
